// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: default pixel width, pool edge and the
// slot order of a packed 2x2 window (also used by max_pooling).
package cnn_pkg;

  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned POOL_SIZE = 2;
  localparam int unsigned WIN_SLOTS = POOL_SIZE * POOL_SIZE;

  // Slot positions inside a packed window, lowest slice first.
  localparam int unsigned TL = 0;
  localparam int unsigned TR = 1;
  localparam int unsigned BL = 2;
  localparam int unsigned BR = 3;

  // Bit offset of a window slot for a given pixel width.
  function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned dsize);
    return slot * dsize;
  endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel stream in, packed 2x2 window and frame bookkeeping out.
interface pool_window_gen_if #(
  parameter int unsigned DATA_SIZE = cnn_pkg::DATA_SIZE,
  parameter int unsigned IMG_W     = 8,
  parameter int unsigned IMG_H     = 8
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WIN_W = DATA_SIZE * cnn_pkg::WIN_SLOTS;

  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic                 win_valid;
  logic [WIN_W-1:0]     win_data;
  logic [COL_W-1:0]     col_idx;
  logic [ROW_W-1:0]     row_idx;
  logic                 frame_done;

  // Pixel source side.
  modport master (
    output in_valid, in_data,
    input  win_valid, win_data, col_idx, row_idx, frame_done
  );

  // Window generator side.
  modport slave (
    input  in_valid, in_data,
    output win_valid, win_data, col_idx, row_idx, frame_done
  );

endinterface

// File: rtl/pool_window_gen_line_buffer.sv
// One-row pixel store: single port, synchronous write, registered read.
// A write takes the port; a read is only performed when no write is requested.
module line_buffer #(
  parameter int unsigned data_size = cnn_pkg::DATA_SIZE,
  parameter int unsigned depth     = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_wr_en,
  input  logic                                        i_rd_en,
  input  logic [((depth > 1) ? $clog2(depth) : 1)-1:0] i_addr,
  input  logic [data_size-1:0]                        i_wr_data,
  output logic [data_size-1:0]                        o_rd_data
);

  logic [data_size-1:0] r_mem [depth];
  logic [data_size-1:0] r_rd_data;

  // Storage array; contents are never cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

  // Registered read data, holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en && !i_wr_en) begin
      r_rd_data <= r_mem[i_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pool_window_gen.sv
// Raster-order pixel stream to non-overlapping 2x2 windows (stride 2).
// Even rows fill the line buffer; odd rows pair with it. The buffer is read
// one column ahead on odd rows so that both top pixels are on hand when the
// bottom-right pixel arrives. Column 0's top pixel is kept in its own
// register because it is written on the same cycle the read-ahead would need.
module pool_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned data_size = DATA_SIZE,
  parameter int unsigned pool_size = POOL_SIZE,
  parameter int unsigned img_w     = 8,
  parameter int unsigned img_h     = 8
) (
  input  logic          clk,
  input  logic          rst,
  pool_window_gen_if.slave bus
);

  localparam int unsigned COL_W = (img_w > 1) ? $clog2(img_w) : 1;
  localparam int unsigned ROW_W = (img_h > 1) ? $clog2(img_h) : 1;
  localparam int unsigned WIN_W = data_size * WIN_SLOTS;

  // Unsupported configurations stop elaboration.
  if (pool_size != 2) begin : g_bad_pool_size
    $error("pool_window_gen: pool_size must be 2");
  end
  if (img_w < 2) begin : g_bad_img_w
    $error("pool_window_gen: img_w must be at least 2");
  end
  if (img_h < 2) begin : g_bad_img_h
    $error("pool_window_gen: img_h must be at least 2");
  end

  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [data_size-1:0] r_held;
  logic [data_size-1:0] r_tl;
  logic [data_size-1:0] r_top0;
  logic                 r_win_valid;
  logic [WIN_W-1:0]     r_win_data;
  logic                 r_frame_done;

  logic [COL_W-1:0]     w_col_nxt;
  logic [ROW_W-1:0]     w_row_nxt;
  logic [data_size-1:0] w_held_nxt;
  logic [data_size-1:0] w_tl_nxt;
  logic [data_size-1:0] w_top0_nxt;
  logic                 w_win_valid_nxt;
  logic [WIN_W-1:0]     w_win_data_nxt;
  logic                 w_frame_done_nxt;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_buf_wr;
  logic                 w_buf_rd;
  logic [COL_W-1:0]     w_buf_addr;
  logic [data_size-1:0] w_rd_data;

  line_buffer #(
    .data_size (data_size),
    .depth     (img_w)
  ) u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_buf_wr),
    .i_rd_en   (w_buf_rd),
    .i_addr    (w_buf_addr),
    .i_wr_data (bus.in_data),
    .o_rd_data (w_rd_data)
  );

  // Counters, buffer access, holding registers and window packing.
  always_comb begin
    w_col_nxt        = r_col;
    w_row_nxt        = r_row;
    w_held_nxt       = r_held;
    w_tl_nxt         = r_tl;
    w_top0_nxt       = r_top0;
    w_win_valid_nxt  = 1'b0;
    w_win_data_nxt   = r_win_data;
    w_frame_done_nxt = 1'b0;
    w_buf_wr         = 1'b0;
    w_buf_rd         = 1'b0;
    w_buf_addr       = r_col;
    w_col_last       = (r_col == COL_W'(img_w - 1));
    w_row_last       = (r_row == ROW_W'(img_h - 1));

    if (bus.in_valid) begin
      if (w_col_last) begin
        w_col_nxt = '0;
        if (w_row_last) begin
          w_row_nxt        = '0;
          w_frame_done_nxt = 1'b1;
        end else begin
          w_row_nxt = r_row + ROW_W'(1);
        end
      end else begin
        w_col_nxt = r_col + COL_W'(1);
      end

      if (!r_row[0]) begin
        w_buf_wr = 1'b1;
        if (r_col == '0) begin
          w_top0_nxt = bus.in_data;
        end
      end else begin
        if (!w_col_last) begin
          w_buf_rd   = 1'b1;
          w_buf_addr = r_col + COL_W'(1);
        end
        if (!r_col[0]) begin
          w_held_nxt = bus.in_data;
          w_tl_nxt   = (r_col == '0) ? r_top0 : w_rd_data;
        end else begin
          w_win_valid_nxt = 1'b1;
          w_win_data_nxt[slot_lsb(TL, data_size) +: data_size] = r_tl;
          w_win_data_nxt[slot_lsb(TR, data_size) +: data_size] = w_rd_data;
          w_win_data_nxt[slot_lsb(BL, data_size) +: data_size] = r_held;
          w_win_data_nxt[slot_lsb(BR, data_size) +: data_size] = bus.in_data;
        end
      end
    end
  end

  // State and output registers; reset wins over an incoming pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_held       <= '0;
      r_tl         <= '0;
      r_top0       <= '0;
      r_win_valid  <= 1'b0;
      r_win_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_held       <= w_held_nxt;
      r_tl         <= w_tl_nxt;
      r_top0       <= w_top0_nxt;
      r_win_valid  <= w_win_valid_nxt;
      r_win_data   <= w_win_data_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.win_valid  = r_win_valid;
  assign bus.win_data   = r_win_data;
  assign bus.col_idx    = r_col;
  assign bus.row_idx    = r_row;
  assign bus.frame_done = r_frame_done;

endmodule
